// File: rtl/tmr_majority_voter.sv
`default_nettype none
// ============================================================================
// Module      : tmr_majority_voter
// Description : Triple-modular-redundancy voter. It votes three replica words
//               bit by bit and tracks which replica keeps disagreeing. After
//               FAULT_THRESH consecutive evaluated cycles in which the same
//               replica deviates, that replica is excluded (DEGRADED) and a
//               resync is requested. If the two remaining replicas then
//               disagree, the block enters FAIL, which only rst can leave.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid, in_a/b/c     - replica words, field k at [k*WIDTH +: WIDTH]
//               out_valid, out_data    - voted word (registered, 1-cycle latency)
//               dev_vec                - {C,B,A} replicas that deviated
//               state                  - 0 NORMAL, 1 SUSPECT, 2 DEGRADED, 3 FAIL
//               faulty_id              - excluded replica (0 A, 1 B, 2 C, 3 none)
//               resync_req, resync_ack - replica-resync handshake
//               err_count              - saturating count of disagreeing cycles
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_majority_voter #(
    parameter int WIDTH        = 32,
    parameter int LANES        = 4,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    input  logic [LANES*WIDTH-1:0]   in_c,
    output logic                     out_valid,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [2:0]               dev_vec,
    output logic [1:0]               state,
    output logic [1:0]               faulty_id,
    output logic                     resync_req,
    input  logic                     resync_ack,
    output logic [CNT_W-1:0]         err_count
);

    localparam int W        = LANES * WIDTH;
    localparam int STREAK_W = $clog2(FAULT_THRESH + 1);
    localparam logic [STREAK_W-1:0] C_THRESH    = STREAK_W'(FAULT_THRESH);
    localparam logic [STREAK_W-1:0] C_THRESH_M1 = STREAK_W'(FAULT_THRESH - 1);
    localparam logic [CNT_W-1:0]    C_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEGRADED = 2'd2,
        ST_FAIL     = 2'd3
    } state_t;

    // Registered state and outputs
    state_t              r_state;
    logic                r_out_valid;
    logic [W-1:0]        r_out_data;
    logic [2:0]          r_dev_vec;
    logic [1:0]          r_faulty_id;
    logic [1:0]          r_suspect_id;
    logic [STREAK_W-1:0] r_streak;
    logic                r_resync_req;
    logic [CNT_W-1:0]    r_err_count;

    // Next-state values
    state_t              w_state;
    logic                w_out_valid;
    logic [W-1:0]        w_out_data;
    logic [2:0]          w_dev_vec;
    logic [1:0]          w_faulty_id;
    logic [1:0]          w_suspect_id;
    logic [STREAK_W-1:0] w_streak;
    logic                w_resync_req;
    logic [CNT_W-1:0]    w_err_count;

    // Voting datapath
    logic [W-1:0] w_maj;
    logic [2:0]   w_dev;
    logic         w_single;
    logic [1:0]   w_dev_id;
    logic [W-1:0] w_keep_lo;
    logic [W-1:0] w_keep_hi;
    logic [2:0]   w_pair_mask;
    logic         w_pair_miss;
    logic         w_err_inc;

    assign w_maj = (in_a & in_b) | (in_b & in_c) | (in_a & in_c);
    assign w_dev = {(in_c != w_maj), (in_b != w_maj), (in_a != w_maj)};

    // A lone deviation implies the other two words equal the majority, so a
    // one-hot w_dev can never coincide with the all-pairwise-unequal case.
    always_comb begin
        w_single = 1'b0;
        w_dev_id = 2'd0;
        case (w_dev)
            3'b001:  begin w_single = 1'b1; w_dev_id = 2'd0; end
            3'b010:  begin w_single = 1'b1; w_dev_id = 2'd1; end
            3'b100:  begin w_single = 1'b1; w_dev_id = 2'd2; end
            default: begin w_single = 1'b0; w_dev_id = 2'd0; end
        endcase
    end

    // Remaining pair while one replica is excluded; w_keep_lo is the lower id.
    always_comb begin
        w_keep_lo   = in_a;
        w_keep_hi   = in_b;
        w_pair_mask = 3'b011;
        case (r_faulty_id)
            2'd0:    begin w_keep_lo = in_b; w_keep_hi = in_c; w_pair_mask = 3'b110; end
            2'd1:    begin w_keep_lo = in_a; w_keep_hi = in_c; w_pair_mask = 3'b101; end
            default: begin w_keep_lo = in_a; w_keep_hi = in_b; w_pair_mask = 3'b011; end
        endcase
    end

    assign w_pair_miss = (w_keep_lo != w_keep_hi);

    // Next-state and output logic
    always_comb begin
        w_state      = r_state;
        w_out_valid  = 1'b0;
        w_out_data   = r_out_data;
        w_dev_vec    = r_dev_vec;
        w_faulty_id  = r_faulty_id;
        w_suspect_id = r_suspect_id;
        w_streak     = r_streak;
        w_resync_req = r_resync_req;
        w_err_inc    = 1'b0;

        case (r_state)
            ST_NORMAL, ST_SUSPECT: begin
                w_resync_req = 1'b0;
                if (in_valid) begin
                    w_out_valid = 1'b1;
                    w_out_data  = w_maj;
                    w_dev_vec   = w_dev;
                    w_err_inc   = (w_dev != 3'b000);
                    if (w_single) begin
                        if ((r_state == ST_SUSPECT) && (w_dev_id == r_suspect_id)) begin
                            if (r_streak >= C_THRESH_M1) begin
                                w_state      = ST_DEGRADED;
                                w_faulty_id  = r_suspect_id;
                                w_resync_req = 1'b1;
                                w_streak     = C_THRESH;
                            end else begin
                                w_streak = r_streak + STREAK_W'(1);
                            end
                        end else begin
                            w_suspect_id = w_dev_id;
                            w_streak     = STREAK_W'(1);
                            if (FAULT_THRESH == 1) begin
                                w_state      = ST_DEGRADED;
                                w_faulty_id  = w_dev_id;
                                w_resync_req = 1'b1;
                            end else begin
                                w_state = ST_SUSPECT;
                            end
                        end
                    end else begin
                        // Full agreement, multiple deviations or no majority.
                        w_state  = ST_NORMAL;
                        w_streak = '0;
                    end
                end
            end

            ST_DEGRADED: begin
                if (in_valid && w_pair_miss) begin
                    // Pair mismatch wins over a simultaneous resync_ack.
                    w_state      = ST_FAIL;
                    w_dev_vec    = w_pair_mask;
                    w_resync_req = 1'b0;
                    w_err_inc    = 1'b1;
                end else begin
                    if (in_valid) begin
                        w_out_valid = 1'b1;
                        w_out_data  = w_keep_lo;
                        w_dev_vec   = 3'b000;
                    end
                    if (resync_ack) begin
                        w_state      = ST_NORMAL;
                        w_faulty_id  = 2'd3;
                        w_resync_req = 1'b0;
                        w_streak     = '0;
                    end
                end
            end

            default: begin
                // FAIL: everything frozen until reset.
                w_resync_req = 1'b0;
            end
        endcase

        w_err_count = r_err_count;
        if (w_err_inc && (r_err_count != C_CNT_MAX)) begin
            w_err_count = r_err_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_NORMAL;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_dev_vec    <= 3'b000;
            r_faulty_id  <= 2'd3;
            r_suspect_id <= 2'd0;
            r_streak     <= '0;
            r_resync_req <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state;
            r_out_valid  <= w_out_valid;
            r_out_data   <= w_out_data;
            r_dev_vec    <= w_dev_vec;
            r_faulty_id  <= w_faulty_id;
            r_suspect_id <= w_suspect_id;
            r_streak     <= w_streak;
            r_resync_req <= w_resync_req;
            r_err_count  <= w_err_count;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign dev_vec    = r_dev_vec;
    assign state      = r_state;
    assign faulty_id  = r_faulty_id;
    assign resync_req = r_resync_req;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/tmr_majority_voter.md
TMR_MAJORITY_VOTER -- requirements
Module: tmr_majority_voter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the bit width of one voted field.
REQ-002 The module SHALL have parameter LANES, default 4, meaning the number of fields voted per replica, so the replica word is W = LANES*WIDTH bits.
REQ-003 The module SHALL have parameter FAULT_THRESH, default 3, meaning the number of consecutive valid cycles in which the same replica deviates before that replica is excluded; legal range is 1..15.
REQ-004 The module SHALL have parameter CNT_W, default 16, meaning the width of the error counter.
REQ-005 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The module SHALL have port in_valid, input, width 1: the replica words are valid this cycle.
REQ-008 The module SHALL have ports in_a, in_b and in_c, input, width W each: replica A/B/C words, with field k at bits [k*WIDTH +: WIDTH].
REQ-009 The module SHALL have port out_valid, output, width 1: out_data is valid.
REQ-010 The module SHALL have port out_data, output, width W: the voted word.
REQ-011 The module SHALL have port dev_vec, output, width 3: the replicas {C,B,A} that deviated in the last voted cycle.
REQ-012 The module SHALL have port state, output, width 2: 0=NORMAL, 1=SUSPECT, 2=DEGRADED, 3=FAIL.
REQ-013 The module SHALL have port faulty_id, output, width 2: the excluded replica (0=A, 1=B, 2=C, 3=none).
REQ-014 The module SHALL have port resync_req, output, width 1, and port resync_ack, input, width 1: the replica-resync handshake.
REQ-015 The module SHALL have port err_count, output, width CNT_W: a saturating count of cycles with a disagreement.

Function
REQ-016 All outputs SHALL be registered, with latency of exactly 1 cycle from an input sample to out_data, out_valid and dev_vec.
REQ-017 Only cycles with in_valid=1 SHALL be evaluated; on cycles with in_valid=0, out_valid=0 and out_data, dev_vec, state, streak and err_count hold their values.
REQ-018 In NORMAL and SUSPECT, out_data SHALL be the bitwise majority ((a&b)|(b&c)|(a&c)) over the full W bits.
REQ-019 In NORMAL and SUSPECT, replica X SHALL deviate when its full word differs from the majority word, and "no majority" SHALL mean all three words are pairwise unequal.
REQ-020 In NORMAL, when exactly one replica deviates, the block SHALL go to SUSPECT with suspect_id set to that replica and streak=1 (or straight to DEGRADED if FAULT_THRESH=1).
REQ-021 In SUSPECT, when the same replica deviates, streak SHALL increment, and on reaching FAULT_THRESH the block SHALL go to DEGRADED, set faulty_id=suspect_id and set resync_req=1.
REQ-022 In SUSPECT, when a different single replica deviates, the block SHALL set suspect_id to the new replica and streak=1.
REQ-023 In SUSPECT, when all replicas agree, the block SHALL go to NORMAL and clear streak.
REQ-024 In NORMAL or SUSPECT, on two or more deviations or no majority, the block SHALL output the bitwise majority, go to NORMAL and clear streak.
REQ-025 In DEGRADED, the two non-excluded replicas SHALL be compared: if equal, out_data is the lower-id remaining replica and dev_vec=0.
REQ-026 In DEGRADED, if the two non-excluded replicas differ, the block SHALL go to FAIL, set dev_vec to the remaining two bits, and hold out_data at its previous value for that cycle.
REQ-027 In DEGRADED, resync_req SHALL stay at 1 until resync_ack=1 is sampled.
REQ-028 When resync_ack=1 is sampled in DEGRADED, the next cycle SHALL have state=NORMAL, faulty_id=3, resync_req=0 and streak=0.
REQ-029 resync_ack SHALL be ignored outside DEGRADED.
REQ-030 If a remaining-pair mismatch and resync_ack=1 occur in the same cycle, the transition to FAIL SHALL take priority.
REQ-031 In FAIL, out_valid SHALL be 0, resync_req=0, and out_data and faulty_id hold their values; the only exit from FAIL is rst.
REQ-032 err_count SHALL increment by 1 on each evaluated cycle with any deviation, no majority, or a remaining-pair mismatch.
REQ-033 err_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-034 Streak SHALL be ceil(log2(FAULT_THRESH+1)) bits wide and never exceed FAULT_THRESH.

Reset
REQ-035 While rst=1 at a clk edge, the next state SHALL be out_valid=0, out_data=0, dev_vec=0, state=NORMAL, faulty_id=3, suspect_id=0, streak=0, resync_req=0 and err_count=0.
REQ-036 rst=1 SHALL override all other inputs, including during a pending resync handshake or in FAIL.
REQ-037 The first input evaluated after rst falls SHALL be the one sampled at the first edge with rst=0.

Verification
REQ-038 The bench SHALL cover: a=b=c=32'h1234_5678 (per field), in_valid=1 -> next cycle out_data equals the input, out_valid=1, dev_vec=0, state=0, err_count=0.
REQ-039 The bench SHALL cover: in_b bit 0 flipped for 1 valid cycle, then clean -> out_data correct throughout, dev_vec=3'b010, then state=1, then state=0, err_count=1.
REQ-040 The bench SHALL cover: in_c corrupted for 3 consecutive valid cycles (FAULT_THRESH=3), with in_valid=0 gaps between them -> state=2, faulty_id=2, resync_req=1, err_count=3, out_data always correct.
REQ-041 The bench SHALL cover: in DEGRADED, resync_ack pulsed for 1 cycle -> next cycle state=0, faulty_id=3, resync_req=0.
REQ-042 The bench SHALL cover: in DEGRADED with faulty_id=2, in_a != in_b together with resync_ack=1 -> state=3, out_valid=0, resync_req=0; FAIL persists until rst.
REQ-043 The bench SHALL cover: with CNT_W=2, 5 deviating cycles -> err_count=3; rst asserted mid-SUSPECT -> all outputs take their REQ-035 values next cycle.
